// File: rtl/axil_ram_arb.sv
// axil_ram_arb: two-port AXI4-Lite arbiter serializing whole transactions onto one RAM slave port
module axil_ram_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

    state_t r_state;
    logic   r_grant, r_last, r_aw_done, r_w_done;

    logic w_wreq0, w_wreq1, w_req0, w_req1, w_win, w_win_wr;
    logic w_waddr, w_wresp, w_raddr, w_rresp;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    // a port requests a write only when both address and data are offered; writes beat reads
    assign w_wreq0  = s0_axil_awvalid && s0_axil_wvalid;
    assign w_wreq1  = s1_axil_awvalid && s1_axil_wvalid;
    assign w_req0   = w_wreq0 || s0_axil_arvalid;
    assign w_req1   = w_wreq1 || s1_axil_arvalid;
    assign w_win    = (w_req0 && w_req1) ? (ROUND_ROBIN != 0 ? !r_last : 1'b0) : w_req1;
    assign w_win_wr = w_win ? w_wreq1 : w_wreq0;

    // reset gating keeps every handshake signal low while rst is held
    assign w_waddr = !rst && r_state == WADDR;
    assign w_wresp = !rst && r_state == WRESP;
    assign w_raddr = !rst && r_state == RADDR;
    assign w_rresp = !rst && r_state == RRESP;

    assign m_axil_awaddr  = r_grant ? s1_axil_awaddr : s0_axil_awaddr;
    assign m_axil_awprot  = r_grant ? s1_axil_awprot : s0_axil_awprot;
    assign m_axil_wdata   = r_grant ? s1_axil_wdata : s0_axil_wdata;
    assign m_axil_wstrb   = r_grant ? s1_axil_wstrb : s0_axil_wstrb;
    assign m_axil_araddr  = r_grant ? s1_axil_araddr : s0_axil_araddr;
    assign m_axil_arprot  = r_grant ? s1_axil_arprot : s0_axil_arprot;
    assign m_axil_awvalid = w_waddr && !r_aw_done && (r_grant ? s1_axil_awvalid : s0_axil_awvalid);
    assign m_axil_wvalid  = w_waddr && !r_w_done && (r_grant ? s1_axil_wvalid : s0_axil_wvalid);
    assign m_axil_bready  = w_wresp && (r_grant ? s1_axil_bready : s0_axil_bready);
    assign m_axil_arvalid = w_raddr && (r_grant ? s1_axil_arvalid : s0_axil_arvalid);
    assign m_axil_rready  = w_rresp && (r_grant ? s1_axil_rready : s0_axil_rready);

    assign s0_axil_awready = w_waddr && !r_grant && !r_aw_done && m_axil_awready;
    assign s0_axil_wready  = w_waddr && !r_grant && !r_w_done && m_axil_wready;
    assign s0_axil_bvalid  = w_wresp && !r_grant && m_axil_bvalid;
    assign s0_axil_arready = w_raddr && !r_grant && m_axil_arready;
    assign s0_axil_rvalid  = w_rresp && !r_grant && m_axil_rvalid;
    assign s1_axil_awready = w_waddr && r_grant && !r_aw_done && m_axil_awready;
    assign s1_axil_wready  = w_waddr && r_grant && !r_w_done && m_axil_wready;
    assign s1_axil_bvalid  = w_wresp && r_grant && m_axil_bvalid;
    assign s1_axil_arready = w_raddr && r_grant && m_axil_arready;
    assign s1_axil_rvalid  = w_rresp && r_grant && m_axil_rvalid;
    assign s0_axil_bresp   = m_axil_bresp;
    assign s1_axil_bresp   = m_axil_bresp;
    assign s0_axil_rdata   = m_axil_rdata;
    assign s1_axil_rdata   = m_axil_rdata;
    assign s0_axil_rresp   = m_axil_rresp;
    assign s1_axil_rresp   = m_axil_rresp;

    assign w_aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_w_hs  = m_axil_wvalid && m_axil_wready;
    assign w_b_hs  = m_axil_bvalid && m_axil_bready;
    assign w_ar_hs = m_axil_arvalid && m_axil_arready;
    assign w_r_hs  = m_axil_rvalid && m_axil_rready;

    // transaction sequencer: grant in IDLE, then hold the grant until the response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_req0 || w_req1) begin
                    r_grant <= w_win;
                    r_last  <= w_win;
                    r_state <= w_win_wr ? WADDR : RADDR;
                end
                WADDR: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= WRESP;
                end else begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs) r_w_done <= 1'b1;
                end
                WRESP: if (w_b_hs) r_state <= IDLE;
                RADDR: if (w_ar_hs) r_state <= RRESP;
                RRESP: if (w_r_hs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_ram_arb.sv
// tb_axil_ram_arb: round-robin and fixed-priority arbiters, each fronting a behavioural RAM slave
module tb_axil_ram_arb;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [15:0] awaddr [2][2], araddr [2][2];
    logic [2:0]  awprot [2][2], arprot [2][2];
    logic [31:0] wdata  [2][2], rdata  [2][2];
    logic [3:0]  wstrb  [2][2];
    logic [1:0]  bresp  [2][2], rresp  [2][2];
    logic awvalid [2][2], awready [2][2], wvalid [2][2], wready [2][2], bvalid [2][2], bready [2][2];
    logic arvalid [2][2], arready [2][2], rvalid [2][2], rready [2][2];
    logic [15:0] m_awaddr [2], m_araddr [2];
    logic [2:0]  m_awprot [2], m_arprot [2];
    logic [31:0] m_wdata [2], m_rdata [2];
    logic [3:0]  m_wstrb [2];
    logic [1:0]  m_bresp [2], m_rresp [2];
    logic m_awvalid [2], m_awready [2], m_wvalid [2], m_wready [2], m_bvalid [2], m_bready [2];
    logic m_arvalid [2], m_arready [2], m_rvalid [2], m_rready [2];
    int aw_dly [2], w_dly [2];

    for (genvar k = 0; k < 2; k++) begin : g_inst
        axil_ram_arb #(.ROUND_ROBIN(k == 0 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst),
            .s0_axil_awaddr(awaddr[k][0]), .s0_axil_awprot(awprot[k][0]), .s0_axil_awvalid(awvalid[k][0]), .s0_axil_awready(awready[k][0]),
            .s0_axil_wdata(wdata[k][0]), .s0_axil_wstrb(wstrb[k][0]), .s0_axil_wvalid(wvalid[k][0]), .s0_axil_wready(wready[k][0]),
            .s0_axil_bresp(bresp[k][0]), .s0_axil_bvalid(bvalid[k][0]), .s0_axil_bready(bready[k][0]),
            .s0_axil_araddr(araddr[k][0]), .s0_axil_arprot(arprot[k][0]), .s0_axil_arvalid(arvalid[k][0]), .s0_axil_arready(arready[k][0]),
            .s0_axil_rdata(rdata[k][0]), .s0_axil_rresp(rresp[k][0]), .s0_axil_rvalid(rvalid[k][0]), .s0_axil_rready(rready[k][0]),
            .s1_axil_awaddr(awaddr[k][1]), .s1_axil_awprot(awprot[k][1]), .s1_axil_awvalid(awvalid[k][1]), .s1_axil_awready(awready[k][1]),
            .s1_axil_wdata(wdata[k][1]), .s1_axil_wstrb(wstrb[k][1]), .s1_axil_wvalid(wvalid[k][1]), .s1_axil_wready(wready[k][1]),
            .s1_axil_bresp(bresp[k][1]), .s1_axil_bvalid(bvalid[k][1]), .s1_axil_bready(bready[k][1]),
            .s1_axil_araddr(araddr[k][1]), .s1_axil_arprot(arprot[k][1]), .s1_axil_arvalid(arvalid[k][1]), .s1_axil_arready(arready[k][1]),
            .s1_axil_rdata(rdata[k][1]), .s1_axil_rresp(rresp[k][1]), .s1_axil_rvalid(rvalid[k][1]), .s1_axil_rready(rready[k][1]),
            .m_axil_awaddr(m_awaddr[k]), .m_axil_awprot(m_awprot[k]), .m_axil_awvalid(m_awvalid[k]), .m_axil_awready(m_awready[k]),
            .m_axil_wdata(m_wdata[k]), .m_axil_wstrb(m_wstrb[k]), .m_axil_wvalid(m_wvalid[k]), .m_axil_wready(m_wready[k]),
            .m_axil_bresp(m_bresp[k]), .m_axil_bvalid(m_bvalid[k]), .m_axil_bready(m_bready[k]),
            .m_axil_araddr(m_araddr[k]), .m_axil_arprot(m_arprot[k]), .m_axil_arvalid(m_arvalid[k]), .m_axil_arready(m_arready[k]),
            .m_axil_rdata(m_rdata[k]), .m_axil_rresp(m_rresp[k]), .m_axil_rvalid(m_rvalid[k]), .m_axil_rready(m_rready[k])
        );

        // RAM slave: AW/W accepted independently after a programmable wait, one-cycle B and R latency
        logic [31:0] mem [1024];
        int aw_cnt, w_cnt, ar_cnt, wr_cnt;
        logic have_aw, have_w, r_bvalid, r_rvalid;
        logic [15:0] a_q;
        logic [31:0] d_q, r_rdata;
        logic [3:0] s_q;
        wire aw_hs = m_awvalid[k] && m_awready[k];
        wire w_hs = m_wvalid[k] && m_wready[k];
        wire ar_hs = m_arvalid[k] && m_arready[k];
        wire [15:0] cur_a = aw_hs ? m_awaddr[k] : a_q;
        wire [31:0] cur_d = w_hs ? m_wdata[k] : d_q;
        wire [3:0] cur_s = w_hs ? m_wstrb[k] : s_q;
        assign m_awready[k] = m_awvalid[k] && !have_aw && aw_cnt >= aw_dly[k];
        assign m_wready[k] = m_wvalid[k] && !have_w && w_cnt >= w_dly[k];
        assign m_arready[k] = m_arvalid[k] && !r_rvalid && ar_cnt >= 1;
        assign m_bvalid[k] = r_bvalid;
        assign m_rvalid[k] = r_rvalid;
        assign m_rdata[k] = r_rdata;
        assign m_bresp[k] = 2'b00;
        assign m_rresp[k] = 2'b00;
        always @(posedge clk) begin
            if (rst) begin
                aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; wr_cnt <= 0;
                have_aw <= 0; have_w <= 0; r_bvalid <= 0; r_rvalid <= 0;
            end else begin
                aw_cnt <= (m_awvalid[k] && !aw_hs) ? aw_cnt + 1 : 0;
                w_cnt <= (m_wvalid[k] && !w_hs) ? w_cnt + 1 : 0;
                ar_cnt <= (m_arvalid[k] && !ar_hs) ? ar_cnt + 1 : 0;
                if (r_bvalid && m_bready[k]) r_bvalid <= 0;
                if (aw_hs) begin have_aw <= 1; a_q <= m_awaddr[k]; end
                if (w_hs) begin have_w <= 1; d_q <= m_wdata[k]; s_q <= m_wstrb[k]; end
                if ((have_aw || aw_hs) && (have_w || w_hs)) begin
                    for (int b = 0; b < 4; b++)
                        if (cur_s[b]) mem[cur_a[11:2]][8*b +: 8] <= cur_d[8*b +: 8];
                    wr_cnt <= wr_cnt + 1;
                    have_aw <= 0;
                    have_w <= 0;
                    r_bvalid <= 1;
                end
                if (ar_hs) begin r_rvalid <= 1; r_rdata <= mem[m_araddr[k][11:2]]; end
                else if (r_rvalid && m_rready[k]) r_rvalid <= 0;
            end
        end
    end

    typedef struct packed {logic inst; logic port; logic wr; logic [31:0] data;} exp_t;
    typedef struct packed {logic inst; logic port; logic wr; logic [15:0] addr; logic [31:0] data; logic [3:0] strb; logic [31:0] exp;} vec_t;
    exp_t q[$];
    int checks = 0, passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push(input logic i, input logic p, input logic w, input logic [31:0] d);
        q.push_back('{i, p, w, d});
    endtask

    task automatic sb(input int i, input int p, input logic w, input logic [31:0] d);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            $display("FAIL sb_extra: got response inst %0d port %0d write %0d, expected none", i, p, w);
            return;
        end
        e = q.pop_front();
        check("sb_order", 32'({i[0], p[0], w}), 32'({e.inst, e.port, e.wr}));
        check("sb_data", d, e.data);
    endtask

    // scoreboard: each completed response handshake pops the oldest expectation
    always @(negedge clk) begin
        #2;
        if (!rst)
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    if (bvalid[i][p] && bready[i][p]) sb(i, p, 1'b1, 32'(bresp[i][p]));
                    if (rvalid[i][p] && rready[i][p]) sb(i, p, 1'b0, rdata[i][p]);
                end
    end

    task automatic wr(input int i, input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic ha = 0, hw = 0;
        int n = 0;
        awaddr[i][p] = a; awprot[i][p] = 3'd2; wdata[i][p] = d; wstrb[i][p] = s;
        awvalid[i][p] = 1; wvalid[i][p] = 1;
        while ((awvalid[i][p] || wvalid[i][p]) && n < 100) begin
            @(negedge clk);
            n++;
            if (ha) awvalid[i][p] = 0;
            if (hw) wvalid[i][p] = 0;
            #1;
            ha = awvalid[i][p] && awready[i][p];
            hw = wvalid[i][p] && wready[i][p];
        end
        if (awvalid[i][p] || wvalid[i][p]) begin
            check("wr_timeout", 32'(n), 32'd0);
            awvalid[i][p] = 0; wvalid[i][p] = 0;
        end
    endtask

    task automatic rd(input int i, input int p, input logic [15:0] a);
        logic ha = 0;
        int n = 0;
        araddr[i][p] = a; arprot[i][p] = 3'd1; arvalid[i][p] = 1;
        while (arvalid[i][p] && n < 100) begin
            @(negedge clk);
            n++;
            if (ha) arvalid[i][p] = 0;
            #1;
            ha = arvalid[i][p] && arready[i][p];
        end
        if (arvalid[i][p]) begin
            check("rd_timeout", 32'(n), 32'd0);
            arvalid[i][p] = 0;
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin check("sb_pending", 32'(q.size()), 32'd0); q.delete(); end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!bvalid[0][1] && n < 50) begin @(negedge clk); n++; end
        if (!bvalid[0][1]) check("bp_wait", 32'(bvalid[0][1]), 32'd1);
    endtask

    vec_t vt[10];

    initial begin
        int c0;
        vt[0] = '{0, 0, 1, 16'h0100, 32'hCAFEF00D, 4'hF, 32'h0};
        vt[1] = '{0, 1, 0, 16'h0010, 32'h0, 4'h0, 32'hAAAA5555};
        vt[2] = '{0, 0, 0, 16'h0014, 32'h0, 4'h0, 32'h12345678};
        vt[3] = '{0, 1, 0, 16'h0018, 32'h0, 4'h0, 32'h0F0F0F0F};
        vt[4] = '{0, 1, 1, 16'h0020, 32'h11223344, 4'hF, 32'h0};
        vt[5] = '{0, 1, 1, 16'h0020, 32'hAABBCCDD, 4'h5, 32'h0};
        vt[6] = '{0, 0, 0, 16'h0020, 32'h0, 4'h0, 32'h11BB33DD};
        vt[7] = '{1, 1, 1, 16'h0030, 32'hDEADBEEF, 4'hF, 32'h0};
        vt[8] = '{1, 0, 0, 16'h0030, 32'h0, 4'h0, 32'hDEADBEEF};
        vt[9] = '{0, 0, 1, 16'h0044, 32'hFFFFFFFF, 4'hF, 32'h0};
        for (int i = 0; i < 2; i++) begin
            aw_dly[i] = 1; w_dly[i] = 1;
            for (int p = 0; p < 2; p++) begin
                awaddr[i][p] = 0; awprot[i][p] = 0; awvalid[i][p] = 0;
                wdata[i][p] = 0; wstrb[i][p] = 0; wvalid[i][p] = 0; bready[i][p] = 1;
                araddr[i][p] = 0; arprot[i][p] = 0; arvalid[i][p] = 0; rready[i][p] = 1;
            end
        end
        // reset with every valid raised: nothing may leak out
        awaddr[0][0] = 16'h10; wdata[0][0] = 32'hAAAA5555; wstrb[0][0] = 4'hF;
        awaddr[0][1] = 16'h14; wdata[0][1] = 32'h12345678; wstrb[0][1] = 4'hF;
        for (int p = 0; p < 2; p++) begin awvalid[0][p] = 1; wvalid[0][p] = 1; arvalid[0][p] = 1; end
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'({awready[0][0], wready[0][0], bvalid[0][0], arready[0][0], rvalid[0][0],
                awready[0][1], wready[0][1], bvalid[0][1], arready[0][1], rvalid[0][1],
                m_awvalid[0], m_wvalid[0], m_bready[0], m_arvalid[0], m_rready[0]}), 32'd0);
        end
        // simultaneous writes: s0 first, then s1; s0 re-requesting against pending s1 loses the tie
        arvalid[0][0] = 0; arvalid[0][1] = 0; rst = 0;
        push(0, 0, 1, 0); push(0, 1, 1, 0); push(0, 0, 1, 0);
        fork
            begin wr(0, 0, 16'h10, 32'hAAAA5555, 4'hF); wr(0, 0, 16'h18, 32'h0F0F0F0F, 4'hF); end
            wr(0, 1, 16'h14, 32'h12345678, 4'hF);
            begin @(negedge clk); check("first_grant_p0", 32'({m_awvalid[0], m_awaddr[0], m_awprot[0]}), 32'({1'b1, 16'h10, 3'd2})); end
        join
        wait_empty();
        // table-driven single transactions
        for (int v = 0; v < 10; v++) begin
            push(vt[v].inst, vt[v].port, vt[v].wr, vt[v].exp);
            if (vt[v].wr) wr(int'(vt[v].inst), int'(vt[v].port), vt[v].addr, vt[v].data, vt[v].strb);
            else rd(int'(vt[v].inst), int'(vt[v].port), vt[v].addr);
            wait_empty();
        end
        // port 0 read latency: AR forwarded at T+1, accepted at T+2, data at T+3
        push(0, 0, 0, 32'hCAFEF00D);
        araddr[0][0] = 16'h0100; arvalid[0][0] = 1;
        @(negedge clk);
        check("rd_t1_ar", 32'({m_arvalid[0], m_araddr[0], arready[0][0]}), 32'({1'b1, 16'h0100, 1'b0}));
        @(negedge clk);
        check("rd_t2_arready", 32'(arready[0][0]), 32'd1);
        @(negedge clk);
        check("rd_t3_rvalid", 32'({rvalid[0][0], rvalid[0][1]}), 32'b10);
        check("rd_t3_rdata", rdata[0][0], 32'hCAFEF00D);
        arvalid[0][0] = 0;
        wait_empty();
        // fixed priority: s1 starves until the s0 stream stops
        for (int n = 0; n < 4; n++) push(1, 0, 0, 32'hDEADBEEF);
        push(1, 1, 0, 32'hDEADBEEF);
        fork
            begin repeat (4) rd(1, 0, 16'h30); end
            rd(1, 1, 16'h30);
        join
        wait_empty();
        // backpressure on B: no grant to s0 until s1 takes its response
        push(0, 1, 1, 0); push(0, 0, 0, 32'h55667788);
        bready[0][1] = 0;
        fork
            wr(0, 1, 16'h40, 32'h55667788, 4'hF);
            begin
                wait_bvalid();
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", 32'({bvalid[0][1], m_arvalid[0], arready[0][0]}), 32'b100);
                end
                bready[0][1] = 1;
                @(negedge clk);
                check("bp_idle", 32'(m_arvalid[0]), 32'd0);
                @(negedge clk);
                check("bp_grant", 32'({m_arvalid[0], m_araddr[0]}), 32'({1'b1, 16'h40}));
            end
            begin wait_bvalid(); rd(0, 0, 16'h40); end
        join
        wait_empty();
        // split AW/W: W accepted two cycles ahead of AW, one partial-strobe write lands
        aw_dly[0] = 3;
        c0 = g_inst[0].wr_cnt;
        push(0, 1, 1, 0);
        wr(0, 1, 16'h44, 32'hA1B2C3D4, 4'b0011);
        wait_empty();
        check("split_one_write", 32'(g_inst[0].wr_cnt - c0), 32'd1);
        aw_dly[0] = 1;
        push(0, 1, 0, 32'hFFFFC3D4);
        rd(0, 1, 16'h44);
        wait_empty();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/axil_ram_arb.md
# axil_ram_arb

Two-port AXI4-Lite arbiter that shares the single-port `axil_ram` between the core's instruction-fetch master (port 0) and its load/store master (port 1). It sits directly in front of the RAM's AXI4-Lite slave port and serializes traffic to one complete transaction at a time. Each transaction is a read or a write from one port. It uses round-robin or fixed priority, and routes each response only to the port that issued the request.

## Interface
- `DATA_WIDTH`, default 32: data bus width in bits.
- `ADDR_WIDTH`, default 16: address width in bits.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: width of wstrb.
- `ROUND_ROBIN`, default 1: 1 selects round-robin between ports; 0 selects fixed priority with port 0 highest.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sN_axil_awaddr/awprot/awvalid` in, `sN_axil_awready` out, N = 0,1: widths ADDR_WIDTH/3/1/1; write address from requester N.
- `sN_axil_wdata/wstrb/wvalid` in, `sN_axil_wready` out: widths DATA_WIDTH/STRB_WIDTH/1/1; write data.
- `sN_axil_bresp/bvalid` out, `sN_axil_bready` in: widths 2/1/1; write response.
- `sN_axil_araddr/arprot/arvalid` in, `sN_axil_arready` out: widths ADDR_WIDTH/3/1/1; read address.
- `sN_axil_rdata/rresp/rvalid` out, `sN_axil_rready` in: widths DATA_WIDTH/2/1/1; read data.
- `m_axil_aw*`, `m_axil_w*`, `m_axil_b*`, `m_axil_ar*`, `m_axil_r*`: same signals with directions mirrored; connects to the RAM.

## Operation
- **Per-port request:** write request = awvalid && wvalid; read request = arvalid. Within a port, a write wins over a read.
- **States:**
  - IDLE: evaluate requests.
  - WADDR: forward AW and W to the master port.
  - WRESP: wait for the B handshake.
  - RADDR: forward AR to the master port.
  - RRESP: wait for the R handshake.
- **IDLE:**
  - If no port requests, stay in IDLE.
  - Otherwise pick a winner and register it in `grant`.
  - Go to WADDR or RADDR depending on the winner's request type.
- **Arbitration when ROUND_ROBIN=1:**
  - Priority pointer `last` resets to 1, so port 0 wins first.
  - On a tie the port ≠ `last` wins.
  - `last` updates to the winner on every grant.
- **Arbitration when ROUND_ROBIN=0:** port 0 always wins a tie.
- **WADDR:**
  - Master aw*/w* payload is muxed from the granted port.
  - m_axil_awvalid = granted awvalid && !aw_done; m_axil_wvalid = granted wvalid && !w_done.
  - Granted port's awready/wready mirror the master's readies.
  - Flags `aw_done` and `w_done` set on their handshakes, so AW and W may complete in different cycles.
  - When both flags are set (or both handshakes happen in the same cycle), clear the flags and go to WRESP.
- **WRESP:**
  - Master bresp/bvalid go to the granted port only; m_axil_bready = granted bready.
  - On the B handshake, go to IDLE.
- **RADDR:** forward AR from the granted port; on the AR handshake, go to RRESP.
- **RRESP:** forward rdata/rresp/rvalid to the granted port; m_axil_rready = granted rready; on the R handshake, go to IDLE.
- **Non-granted port:** all of its readies and valids are held 0 in every state. Its requests stay pending, with no drop and no timeout.
- **Responses:** bresp/rresp pass through unmodified.
- **Payload passthrough:** prot passes through unmodified.
- **No hazards:** one transaction is in flight at most, so no ordering or ID logic exists.

## Timing
- **Reset:**
  - State IDLE, `grant`=0, `last`=1, aw_done=w_done=0.
  - Every sN/m valid and ready output is 0.
  - Data outputs are don't-care but driven from the muxes.
  - Reset mid-transaction abandons it immediately. The RAM is reset on the same `rst`.
- **Grant latency:** a request seen in IDLE at cycle T gives m_axil_awvalid/arvalid high at T+1. Payload is combinational from the granted port; no registering of payload.
- **Write path:** with `axil_ram` behind, a write takes AW/W accept at T+2, bvalid at T+3, and a return to IDLE one cycle after the B handshake.
- **Read path:** a read takes arready at T+2 and rvalid at T+3 (PIPELINE_OUTPUT=0).
- **Back-to-back:** minimum one IDLE cycle between consecutive transactions.
- **Request withdrawal:** a requester that drops valid before its handshake violates AXI. No recovery is required, but the arbiter must not deadlock if the request returns.

## Test plan
- **Reset values:** assert rst for 3 cycles with all valids high → all readies/valids 0 during reset. First grant after reset goes to port 0.
- **Port 0 read:** s0 reads 0x0100 → m_axil_araddr=0x0100 at T+1; s0_rvalid with RAM data at T+3; s1_rvalid stays 0.
- **Simultaneous writes, ROUND_ROBIN=1:** s0 writes 0xAAAA5555 to 0x10, s1 writes 0x12345678 to 0x14 in the same cycle → s0 is served first, then s1. Reads of both return the written values. A second tie grants s1 first.
- **Fixed priority:** ROUND_ROBIN=0 with a continuous s0 read stream and a pending s1 read → s1 starves while s0 requests, and is served once s0 idles.
- **Backpressure:** s1 writes while holding bready=0 for 5 cycles → FSM stays in WRESP, s0 gets no grant, and s0 is granted 2 cycles after bready rises.
- **Split AW/W:** stub slave accepts W 2 cycles before AW → exactly one write reaches the slave, and wstrb=4'b0011 is applied as given.
